uart_lite_resp: RTL and testbench

UART_LITE_RESP -- requirements
Module: uart_lite_resp

---
 rtl/uart_lite_resp.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_lite_resp.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite_resp.sv
// uart_lite_resp: AXI4-Lite slave UART with 8N1 transmitter/receiver and
// power-of-two byte FIFOs on both directions.
// Register map (addr[3:2]): 0 RXFIFO, 1 TXFIFO, 2 STAT, 3 CTRL.
// Optional build macro UART_LOOPBACK_EN: feed tx back into the RX
// synchronizer instead of the rx pin (tx pin still drives the line).

module uart_lite_resp #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        rx,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] REG_RXFIFO = 2'd0;
  localparam logic [1:0] REG_TXFIFO = 2'd1;
  localparam logic [1:0] REG_STAT   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  // Bus-side decode
  logic        wr_fire, rd_fire;
  logic [1:0]  wr_sel, rd_sel;
  logic        tx_drop;
  logic [31:0] rd_value;
  logic [31:0] stat;

  // TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [PW:0]   tx_count;
  logic          tx_empty, tx_full, tx_push, tx_pop, tx_flush;

  // RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [PW:0]   rx_count;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_flush;

  // Sticky status
  logic overrun, frame_err, overrun_set, stat_clear;

  // TX engine
  uart_state_t   tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line;
  logic          tx_owns_head;

  // RX engine
  uart_state_t   rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_in, rx_meta, rx_sync, rx_prev;
  logic          rx_stop_tick, rx_byte_ok, rx_byte_bad;

  logic unused_bits;

`ifdef UART_LOOPBACK_EN
  assign rx_in       = tx_line;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata[31:8], s_axi_awaddr[1:0],
                         s_axi_araddr[1:0], rx};
`else
  assign rx_in       = rx;
  assign unused_bits = ^{s_axi_wstrb, s_axi_wdata[31:8], s_axi_awaddr[1:0],
                         s_axi_araddr[1:0]};
`endif

  assign tx          = tx_line;
  assign s_axi_rresp = RESP_OKAY;

  assign wr_sel  = s_axi_awaddr[3:2];
  assign rd_sel  = s_axi_araddr[3:2];
  assign wr_fire = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
  assign rd_fire = s_axi_arready && s_axi_arvalid;

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);

  // The TX engine keeps its byte at the FIFO head until the stop bit ends,
  // so a full FIFO stays full while the first frame is on the wire.
  assign tx_pop   = (tx_state == STOP) && (tx_cnt == BIT_LAST) && tx_owns_head
                    && !tx_empty && !tx_flush;
  assign tx_push  = wr_fire && (wr_sel == REG_TXFIFO) && (!tx_full || tx_pop);
  assign tx_drop  = (wr_sel == REG_TXFIFO) && tx_full && !tx_pop;
  assign tx_flush = wr_fire && (wr_sel == REG_CTRL) && s_axi_wdata[0];
  assign rx_flush = wr_fire && (wr_sel == REG_CTRL) && s_axi_wdata[1];

  assign rx_stop_tick = (rx_state == STOP) && (rx_cnt == BIT_LAST);
  assign rx_byte_ok   = rx_stop_tick && rx_sync;
  assign rx_byte_bad  = rx_stop_tick && !rx_sync;
  assign rx_pop       = rd_fire && (rd_sel == REG_RXFIFO) && !rx_empty && !rx_flush;
  assign rx_push      = rx_byte_ok && (!rx_full || rx_pop) && !rx_flush;
  assign overrun_set  = rx_byte_ok && rx_full && !rx_pop && !rx_flush;
  assign stat_clear   = rd_fire && (rd_sel == REG_STAT);

  assign stat = {25'd0, frame_err, overrun, 1'b0, tx_full, tx_empty, rx_full, !rx_empty};

  // Read-data mux for the register addressed by the pending read
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_value = '0;
    case (rd_sel)
      REG_RXFIFO: if (!rx_empty) rd_value = {24'd0, rx_mem[rx_rd_ptr]};
      REG_STAT:   rd_value = stat;
      default:    rd_value = '0;
    endcase
  end

  // Write channel: one-cycle ready pulse, then hold the response until bready
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      if (!s_axi_awready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= tx_drop ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: one-cycle arready pulse, registered data held until rready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
    end else begin
      s_axi_arready <= 1'b0;
      if (!s_axi_arready && s_axi_arvalid && !s_axi_rvalid) s_axi_arready <= 1'b1;
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_value;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  // Sticky overrun / frame-error flags; a new event wins over a STAT read clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)     overrun <= 1'b1;
      else if (stat_clear) overrun <= 1'b0;
      if (rx_byte_bad)     frame_err <= 1'b1;
      else if (stat_clear) frame_err <= 1'b0;
    end
  end

  // FIFO storage arrays
  // NOTE: storage is not reset; pointers and counts define validity, which keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= s_axi_wdata[7:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  // TX FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // TX engine: 8N1 LSB-first, each bit held CLKS_PER_BIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state     <= IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx_line      <= 1'b1;
      tx_owns_head <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (!tx_empty && !tx_flush) begin
            tx_shift     <= tx_mem[tx_rd_ptr];
            tx_line      <= 1'b0;
            tx_cnt       <= '0;
            tx_owns_head <= 1'b1;
            tx_state     <= START;
          end
        end
        START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= tx_shift[0];
            tx_state <= DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_line  <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_line  <= tx_shift[1];
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt       <= '0;
            tx_owns_head <= 1'b0;
            tx_state     <= IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
      // A flush releases the head; the frame already on the wire still finishes
      if (tx_flush) tx_owns_head <= 1'b0;
    end
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX engine: start-bit recheck at half a bit, then sample at bit centres
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_lite_resp.sv
// tb_uart_lite_resp: directed bench for uart_lite_resp with a short bit
// period. Tests touching the rx pin are replaced by a loopback test when
// UART_LOOPBACK_EN is defined.

module tb_uart_lite_resp;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;

  logic        clk, rst;
  logic [3:0]  s_axi_awaddr;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid, s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_araddr;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid, s_axi_rready;
  logic        rx, tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_lite_resp #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .rx(rx), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- bus helpers ----------------
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axi_awready && s_axi_wready) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL write_ready addr=%h: awready/wready got 0 required 1", addr);
    end else begin
      @(posedge clk);
    end
    #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    resp = 2'b11; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL write_bvalid addr=%h: bvalid got 0 required 1", addr);
    end else begin
      resp = s_axi_bresp;
      s_axi_bready = 1'b1;
      @(posedge clk);
      #1 s_axi_bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit got = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axi_arready) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL read_ready addr=%h: arready got 0 required 1", addr);
    end else begin
      @(posedge clk);
    end
    #1 s_axi_arvalid = 1'b0;
    data = 32'hDEAD_BEEF; resp = 2'b11; got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin got = 1; break; end
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL read_rvalid addr=%h: rvalid got 0 required 1", addr);
    end else begin
      data = s_axi_rdata; resp = s_axi_rresp;
      s_axi_rready = 1'b1;
      @(posedge clk);
      #1 s_axi_rready = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clk); rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b required 00000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid});
    end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx); end
    n_checks++;
    if ({s_axi_rdata, s_axi_bresp, s_axi_rresp} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h bresp=%b rresp=%b required all 0", s_axi_rdata, s_axi_bresp, s_axi_rresp);
    end
    rst = 1'b0;
    @(negedge clk);
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL reset_stat: got %h required 00000004", d); end
    axi_read(4'h4, d, r);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_txfifo_zero: got %h required 00000000", d); end
    axi_read(4'hC, d, r);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL read_ctrl_zero: got %h required 00000000", d); end
  endtask

  task automatic test_tx_frame();
    logic [1:0] resp;
    int low_cnt = 0;
    logic [7:0] got_byte = 8'h00;
    logic stop_seen = 1'b0;
    bit fell = 0;
    fork
      axi_write(4'h4, 32'h55, resp);
      begin
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (tx === 1'b0) begin fell = 1; break; end
        end
        if (fell) begin
          low_cnt = 1;
          for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b0) break;
            low_cnt++;
          end
          repeat (CPB / 2 - 1) @(negedge clk);
          for (int i = 0; i < 8; i++) begin
            got_byte[i] = tx;
            repeat (CPB) @(negedge clk);
          end
          stop_seen = tx;
        end
      end
    join
    n_checks++;
    if (resp !== 2'b00) begin n_fail++; $display("FAIL tx55_bresp: got %b required 00", resp); end
    n_checks++;
    if (!fell) begin n_fail++; $display("FAIL tx55_start: tx never fell, required a start bit"); end
    n_checks++;
    if (low_cnt != CPB) begin n_fail++; $display("FAIL tx55_start_len: got %0d cycles required %0d", low_cnt, CPB); end
    n_checks++;
    if (got_byte !== 8'h55) begin n_fail++; $display("FAIL tx55_data: got %h required 55", got_byte); end
    n_checks++;
    if (stop_seen !== 1'b1) begin n_fail++; $display("FAIL tx55_stop: got %b required 1", stop_seen); end
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic test_rx_byte();
    logic [31:0] d; logic [1:0] r;
    send_rx(8'hA3, 1'b1);
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h05) begin n_fail++; $display("FAIL rx_stat_full: got %h required 00000005", d); end
    axi_read(4'h0, d, r);
    n_checks++;
    if (d !== 32'hA3) begin n_fail++; $display("FAIL rx_data: got %h required 000000a3", d); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL rx_stat_drained: got %h required 00000004", d); end
    axi_read(4'h0, d, r);
    n_checks++;
    if ({d, r} !== 34'd0) begin n_fail++; $display("FAIL rx_empty_read: rdata=%h rresp=%b required 0/00", d, r); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL rx_empty_ptrs: stat got %h required 00000004", d); end
  endtask

  task automatic test_tx_full();
    logic [31:0] d; logic [1:0] r; logic [1:0] want;
    int lows = 0;
`ifdef UART_LOOPBACK_EN
    logic [31:0] stat_idle = 32'h05;
`else
    logic [31:0] stat_idle = 32'h04;
`endif
    axi_write(4'hC, 32'h3, r);
    for (int i = 0; i < 17; i++) begin
      axi_write(4'h4, 32'h30 + i, r);
      want = (i == 16) ? 2'b10 : 2'b00;
      n_checks++;
      if (r !== want) begin n_fail++; $display("FAIL txfull_bresp[%0d]: got %b required %b", i, r, want); end
    end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h08) begin n_fail++; $display("FAIL txfull_stat: got %h required 00000008", d); end
    axi_write(4'hC, 32'h1, r);
    n_checks++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL ctrl_bresp: got %b required 00", r); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL txflush_stat: got %h required 00000004", d); end
    repeat (12 * CPB) @(negedge clk);
    for (int k = 0; k < 4 * CPB; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL txflush_idle: tx low %0d cycles required 0", lows); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== stat_idle) begin n_fail++; $display("FAIL txflush_stat_end: got %h required %h", d, stat_idle); end
  endtask

  task automatic test_overrun();
    logic [31:0] d; logic [1:0] r;
    for (int i = 0; i < 17; i++) send_rx(8'h10 + 8'(i), 1'b1);
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h27) begin n_fail++; $display("FAIL overrun_stat: got %h required 00000027", d); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h07) begin n_fail++; $display("FAIL overrun_cleared: got %h required 00000007", d); end
    axi_read(4'h0, d, r);
    n_checks++;
    if (d !== 32'h10) begin n_fail++; $display("FAIL overrun_first_byte: got %h required 00000010", d); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h05) begin n_fail++; $display("FAIL overrun_after_pop: got %h required 00000005", d); end
    axi_write(4'hC, 32'h2, r);
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL rxflush_stat: got %h required 00000004", d); end
  endtask

  task automatic test_frame_err();
    logic [31:0] d; logic [1:0] r;
    send_rx(8'h5A, 1'b0);
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h44) begin n_fail++; $display("FAIL frame_err_stat: got %h required 00000044", d); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL frame_err_cleared: got %h required 00000004", d); end
    send_rx(8'h3C, 1'b1);
    axi_read(4'h0, d, r);
    n_checks++;
    if (d !== 32'h3C) begin n_fail++; $display("FAIL rx_after_error: got %h required 0000003c", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'hC, 32'h2, r);
    axi_write(4'h4, 32'h3C, r);
    repeat (14 * CPB) @(negedge clk);
    axi_read(4'h0, d, r);
    n_checks++;
    if (d !== 32'h3C) begin n_fail++; $display("FAIL loopback_data: got %h required 0000003c", d); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d; logic [1:0] r;
    int lows = 0;
    axi_write(4'h4, 32'h00, r);
    repeat (3 * CPB) @(negedge clk);
    // leave a read response and a write response outstanding
    s_axi_araddr = 4'h8; s_axi_arvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (s_axi_arready) break; end
    @(posedge clk); #1 s_axi_arvalid = 1'b0;
    s_axi_awaddr = 4'h8; s_axi_wdata = 32'hFF; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    for (int k = 0; k < 20; k++) begin @(negedge clk); if (s_axi_awready) break; end
    @(posedge clk); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tx, s_axi_bvalid, s_axi_rvalid} !== 3'b011) begin
      n_fail++;
      $display("FAIL midframe_pre: tx,bvalid,rvalid got %b required 011", {tx, s_axi_bvalid, s_axi_rvalid});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_rst_tx: got %b required 1", tx); end
    n_checks++;
    if ({s_axi_bvalid, s_axi_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midframe_rst_valid: bvalid,rvalid got %b required 00", {s_axi_bvalid, s_axi_rvalid});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2 * CPB; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_checks++;
    if (lows != 0) begin n_fail++; $display("FAIL midframe_tx_idle: tx low %0d cycles required 0", lows); end
    axi_read(4'h8, d, r);
    n_checks++;
    if (d !== 32'h04) begin n_fail++; $display("FAIL midframe_stat: got %h required 00000004", d); end
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    test_reset();
    test_tx_frame();
`ifndef UART_LOOPBACK_EN
    test_rx_byte();
`endif
    test_tx_full();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`else
    test_overrun();
    test_frame_err();
`endif
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
